// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO in front of a start/data/stop
// serialiser. Bytes go out LSB first on a registered, idle-high line.
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [7:0]                    txData,
    input  logic                          txValid,
    output logic                          txReady,
    output logic                          uartTx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [12:0]      BAUD_LAST  = 13'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txStateT;

    // Handshake: a byte is taken on every rising edge where txValid && txReady.
    // txReady depends only on the registered count, so a pop in the same cycle
    // as a full FIFO does not open a slot until the following cycle.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             haveByte;

    assign txReady   = (count != FULL_COUNT);
    assign push      = txValid && txReady;
    assign haveByte  = (count != '0);
    assign fifoCount = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= txData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    txStateT     state;
    txStateT     stateNext;
    logic [12:0] baudCnt;
    logic [12:0] baudNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic        lineBit;
    logic        baudLast;

    assign baudLast = (baudCnt == BAUD_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            uartTx   <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            uartTx   <= lineBit;
        end
    end

    // The line register lags the state by one cycle, which gives the
    // push-to-falling-edge latency of two cycles.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        pop       = 1'b0;
        lineBit   = 1'b1;
        case (state)
            IDLE: begin
                lineBit = 1'b1;
                if (haveByte) begin
                    pop       = 1'b1;
                    shiftNext = mem[rdPtr];
                    baudNext  = '0;
                    bitNext   = '0;
                    stateNext = START;
                end
            end
            START: begin
                lineBit = 1'b0;
                if (baudLast) begin
                    baudNext  = '0;
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt + 13'd1;
                end
            end
            DATA: begin
                lineBit = shiftReg[bitIdx];
                if (baudLast) begin
                    baudNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitNext = bitIdx + 3'd1;
                    end
                end else begin
                    baudNext = baudCnt + 13'd1;
                end
            end
            STOP: begin
                lineBit = 1'b1;
                if (baudLast) begin
                    baudNext = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (haveByte) begin
                        pop       = 1'b1;
                        shiftNext = mem[rdPtr];
                        bitNext   = '0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext = baudCnt + 13'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames and checks
// them against a queue of bytes recorded when the FIFO accepted them.
module tb_uart_tx_fifo;

    localparam int BIT_CYC = 4;
    localparam int SLOW_CYC = 234;

    logic       clk;
    logic       rstN;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       uartTx;
    logic       busy;
    logic [2:0] fifoCount;

    logic [7:0] txDataSlow;
    logic       txValidSlow;
    logic       txReadySlow;
    logic       uartTxSlow;
    logic       busySlow;
    logic [4:0] fifoCountSlow;

    uart_tx_fifo #(.DELAY_FRAMES(BIT_CYC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstN(rstN), .txData(txData), .txValid(txValid),
        .txReady(txReady), .uartTx(uartTx), .busy(busy), .fifoCount(fifoCount)
    );

    uart_tx_fifo #(.DELAY_FRAMES(SLOW_CYC), .FIFO_DEPTH(16)) dutSlow (
        .clk(clk), .rstN(rstN), .txData(txDataSlow), .txValid(txValidSlow),
        .txReady(txReadySlow), .uartTx(uartTxSlow), .busy(busySlow), .fifoCount(fifoCountSlow)
    );

    // Clock and cycle index
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] expQ[$];
    int         startQ[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: every frame must hold each bit for exactly BIT_CYC samples
    bit         inFrame = 1'b0;
    bit         haveExp;
    bit         frameOk;
    int         sIdx;
    int         framesSeen = 0;
    logic [9:0] expFrame;
    logic [7:0] expByte;
    logic [7:0] decByte;

    always @(negedge clk) begin
        if (!rstN) begin
            inFrame = 1'b0;
        end else begin
            if (!inFrame && uartTx == 1'b0) begin
                inFrame = 1'b1;
                sIdx    = 0;
                frameOk = 1'b1;
                decByte = '0;
                framesSeen++;
                startQ.push_back(cyc);
                if (expQ.size() == 0) begin
                    haveExp  = 1'b0;
                    expFrame = 10'h3fe;
                    check("unexpected_frame", 1, 0);
                end else begin
                    haveExp  = 1'b1;
                    expByte  = expQ.pop_front();
                    expFrame = {1'b1, expByte, 1'b0};
                end
            end
            if (inFrame) begin
                if (uartTx !== expFrame[sIdx / BIT_CYC]) frameOk = 1'b0;
                if ((sIdx % BIT_CYC) == BIT_CYC / 2 && sIdx >= BIT_CYC && sIdx < 9 * BIT_CYC)
                    decByte[(sIdx / BIT_CYC) - 1] = uartTx;
                sIdx++;
                if (sIdx == 10 * BIT_CYC) begin
                    inFrame = 1'b0;
                    if (haveExp) begin
                        checks++;
                        if (!frameOk) begin
                            errors++;
                            $display("FAIL frame: decoded %02h expected %02h (line differs from 10x%0d-cycle frame)",
                                     decByte, expByte, BIT_CYC);
                        end
                    end
                end
            end
        end
    end

    // Driver tasks: called at a negedge, return at a negedge with txValid still high
    task automatic pushByte(input logic [7:0] b, output int acc);
        logic rdy;
        int   guard;
        txData  = b;
        txValid = 1'b1;
        acc     = -1;
        guard   = 0;
        while (acc == -1) begin
            rdy = txReady;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = cyc;
                expQ.push_back(b);
            end else begin
                guard++;
                if (guard > 500) begin
                    check("push_timeout", 0, 1);
                    acc = -2;
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idleInput();
        txValid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || inFrame || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitCycle(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int acc;
        int acc1;
        int acc6;
        int busyCnt;
        int framesBefore;
        int bad;
        bit found;
        logic [9:0] frameSlow;

        rstN        = 1'b0;
        txData      = 8'hEE;
        txValid     = 1'b1;
        txDataSlow  = 8'h00;
        txValidSlow = 1'b0;

        // Reset state, with txValid asserted to show it is ignored
        repeat (3) @(negedge clk);
        check("reset_uartTx", uartTx, 1);
        check("reset_busy", busy, 0);
        check("reset_fifoCount", fifoCount, 0);
        check("reset_txReady", txReady, 1);
        txValid = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        check("no_frame_from_reset_valid", framesSeen, 0);

        // Single byte: latency, busy window, count returns to zero
        startQ.delete();
        pushByte(8'h55, acc);
        idleInput();
        busyCnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) busyCnt++;
            @(negedge clk);
        end
        check("busy_cycles_0x55", busyCnt, 40);
        check("count_after_0x55", fifoCount, 0);
        waitDrain("drain_0x55");
        if (startQ.size() > 0) check("latency_0x55", startQ[0] - acc, 2);
        else check("frame_seen_0x55", 0, 1);

        // Back-to-back frames are contiguous
        startQ.delete();
        pushByte(8'hA3, acc);
        pushByte(8'h0F, acc);
        idleInput();
        waitDrain("drain_a3_0f");
        check("frames_a3_0f", startQ.size(), 2);
        if (startQ.size() == 2) check("gap_a3_0f", startQ[1] - startQ[0], 40);

        // Backpressure: five accepted, sixth held until the first stop completes
        startQ.delete();
        pushByte(8'h01, acc1);
        for (int b = 2; b <= 5; b++) pushByte(8'(b), acc);
        check("full_fifoCount", fifoCount, 4);
        check("full_txReady", txReady, 0);
        pushByte(8'h06, acc6);
        idleInput();
        check("accept_0x06_cycle", acc6 - acc1, 42);
        waitDrain("drain_01_06");
        check("frames_01_06", startQ.size(), 6);

        // Reset during data bit 3 with two bytes queued
        pushByte(8'h3C, acc);
        pushByte(8'h5A, acc1);
        pushByte(8'hC3, acc1);
        idleInput();
        waitCycle(acc + 19);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_count", fifoCount, 2);
        rstN = 1'b0;
        #1;
        check("midreset_uartTx", uartTx, 1);
        check("midreset_count", fifoCount, 0);
        check("midreset_busy", busy, 0);
        expQ.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        framesBefore = framesSeen;
        repeat (100) @(negedge clk);
        check("no_frames_after_reset", framesSeen - framesBefore, 0);
        check("line_idle_after_reset", uartTx, 1);

        // Push coinciding with the STOP-end pop at count 2
        pushByte(8'h11, acc1);
        pushByte(8'h22, acc);
        pushByte(8'h33, acc);
        idleInput();
        waitCycle(acc1 + 40);
        pushByte(8'h44, acc);
        idleInput();
        check("coincide_accept_cycle", acc - acc1, 41);
        check("coincide_count", fifoCount, 2);
        waitDrain("drain_coincide");

        // Pointer wrap: twelve sequential bytes
        for (int b = 0; b < 12; b++) pushByte(8'(8'h80 + b * 7), acc);
        idleInput();
        waitDrain("drain_wrap");
        check("queue_empty_after_wrap", expQ.size(), 0);

        // Full-rate divider smoke test on the second instance
        frameSlow   = {1'b1, 8'h41, 1'b0};
        txDataSlow  = 8'h41;
        txValidSlow = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        txValidSlow = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (uartTxSlow == 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check("slow_start_seen", found, 1);
        check("slow_latency", cyc - acc, 2);
        bad = -1;
        for (int i = 0; i < 10 * SLOW_CYC; i++) begin
            if (uartTxSlow !== frameSlow[i / SLOW_CYC] && bad < 0) bad = i;
            @(negedge clk);
        end
        check("slow_frame_first_bad_sample", bad, -1);
        check("slow_line_after_frame", uartTxSlow, 1);
        check("slow_busy_after_frame", busySlow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
